// File: rtl/puf_challenge_driver.sv
// puf_challenge_driver: LFSR challenge generator and race-pulse sequencer for an arbiter PUF.
// Define PUF_MAJORITY_VOTE_EN to evaluate each challenge VOTES times with majority voting.
module puf_challenge_driver #(
  parameter int RESP_BITS     = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int VOTES         = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           seed,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] resp_word,
  output logic                 unstable,
  output logic [7:0]           chal_out,
  output logic                 puf_pulse,
  input  logic                 puf_resp
);
  localparam int IW = $clog2(RESP_BITS + 1);
  localparam int TW = $clog2(SETTLE_CYCLES);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, FIRE, DONE} state_t;
  if (RESP_BITS < 1 || RESP_BITS > 32 || SETTLE_CYCLES < 3 || VOTES < 3 || VOTES > 15 || VOTES % 2 == 0)
    $error("puf_challenge_driver: illegal parameter value");
  state_t          state_q;
  logic [1:0]      sync_q;
  logic [TW-1:0]   tmr_q;
  logic [IW-1:0]   idx_q;
  logic [7:0]      lfsr_d;
  logic [RESP_BITS-1:0] word_d;
  logic            res_d, last_ev_d, unst_d;
`ifdef PUF_MAJORITY_VOTE_EN
  logic [3:0] ones_q, ev_q, ones_d;
  always_comb begin
    ones_d    = ones_q + {3'b000, sync_q[1]};
    res_d     = ones_d > 4'(VOTES / 2);
    last_ev_d = ev_q == 4'(VOTES - 1);
    unst_d    = ones_d != 4'd0 && ones_d != 4'(VOTES);
  end
`else
  always_comb begin
    res_d     = sync_q[1];
    last_ev_d = 1'b1;
    unst_d    = 1'b0;
  end
`endif
  always_comb begin
    lfsr_d = {chal_out[6:0], chal_out[7] ^ chal_out[5] ^ chal_out[4] ^ chal_out[3]};
    word_d = resp_word | (RESP_BITS'(res_d) << idx_q);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], puf_resp};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      idx_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      resp_word <= '0;
      unstable  <= 1'b0;
      chal_out  <= 8'h00;
      puf_pulse <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
      ones_q    <= 4'd0;
      ev_q      <= 4'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          chal_out  <= seed == 8'h00 ? 8'h01 : seed;
          resp_word <= '0;
          unstable  <= 1'b0;
          idx_q     <= '0;
          tmr_q     <= '0;
          busy      <= 1'b1;
          state_q   <= LOAD;
`ifdef PUF_MAJORITY_VOTE_EN
          ones_q    <= 4'd0;
          ev_q      <= 4'd0;
`endif
        end
        LOAD: begin
          tmr_q   <= '0;
          state_q <= SETTLE;
        end
        SETTLE: if (tmr_q == TW'(SETTLE_CYCLES - 1)) begin
          tmr_q     <= '0;
          puf_pulse <= 1'b1;
          state_q   <= FIRE;
        end else tmr_q <= tmr_q + 1'b1;
        // The last FIRE cycle samples the synchronizer output as one evaluation
        FIRE: if (tmr_q != TW'(SETTLE_CYCLES - 1)) tmr_q <= tmr_q + 1'b1;
        else begin
          tmr_q     <= '0;
          puf_pulse <= 1'b0;
          state_q   <= LOAD;
`ifdef PUF_MAJORITY_VOTE_EN
          ones_q    <= last_ev_d ? 4'd0 : ones_d;
          ev_q      <= last_ev_d ? 4'd0 : ev_q + 4'd1;
`endif
          if (last_ev_d) begin
            resp_word <= word_d;
            unstable  <= unstable | unst_d;
            chal_out  <= lfsr_d;
            idx_q     <= idx_q + 1'b1;
            if (idx_q == IW'(RESP_BITS - 1)) begin
              state_q <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_puf_challenge_driver.sv
// tb_puf_challenge_driver: scoreboard bench for puf_challenge_driver.
module tb_puf_challenge_driver;
  localparam int RB = 8;
  localparam int E  = 9;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int NV = 5;
`else
  localparam int NV = 1;
`endif
  logic clk, rst_n, start, busy, done, unstable, puf_pulse, puf_resp, tgl;
  logic [7:0] seed, chal_out;
  logic [RB-1:0] resp_word;
  int n_chk, n_err, mode, pulses, cyc, done_cnt;
  logic busy_p, pulse_p;
  logic [31:0] exp_chal[$], exp_word[$], exp_unst[$], exp_cyc[$];
  logic [31:0] last_w;
  puf_challenge_driver dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .busy(busy), .done(done),
    .resp_word(resp_word), .unstable(unstable), .chal_out(chal_out),
    .puf_pulse(puf_pulse), .puf_resp(puf_resp)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial tgl = 1'b0;
  always #7 tgl = ~tgl;
  assign puf_resp = mode == 0 ? chal_out[0] : mode == 1 ? 1'b1 : mode == 2 ? (pulses <= 3) : tgl;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    busy_p = 1'b0; pulse_p = 1'b0; cyc = 0; pulses = 0; done_cnt = 0;
  end
  always @(negedge clk) begin
    if (busy && !busy_p) begin
      cyc = 1;
      pulses = 0;
    end else cyc++;
    if (puf_pulse && !pulse_p) begin
      pulses++;
      check("chal_avail", exp_chal.size() > 0, 1);
      if (exp_chal.size() > 0) check("chal_out", chal_out, exp_chal.pop_front());
    end
    if (done) begin
      done_cnt++;
      check("busy_at_done", busy, 0);
      check("busy_before_done", busy_p, 1);
      check("done_avail", exp_cyc.size() > 0, 1);
      if (exp_cyc.size() > 0) begin
        check("done_cycle", cyc, exp_cyc.pop_front());
        check("resp_word", resp_word, exp_word.pop_front());
        check("unstable", unstable, exp_unst.pop_front());
      end
    end
    busy_p = busy;
    pulse_p = puf_pulse;
  end
  task automatic arm(input logic [7:0] s, input int m);
    logic [7:0] c;
    logic [31:0] w;
    c = s == 8'h00 ? 8'h01 : s;
    w = 0;
    mode = m;
    done_cnt = 0;
    for (int i = 0; i < RB; i++) begin
      for (int v = 0; v < NV; v++) exp_chal.push_back(c);
      w[i] = m == 0 ? c[0] : m == 1 ? 1'b1 : (i == 0);
      c = {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
    end
    last_w = w;
    exp_word.push_back(w);
    exp_unst.push_back(m == 2);
    exp_cyc.push_back(RB * NV * E + 1);
    @(negedge clk);
    seed = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input int restart_at);
    for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
      @(negedge clk);
      #1;
      start = restart_at > 0 && cyc == restart_at;
    end
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("done_count", done_cnt, 1);
    check("busy_idle", busy, 0);
    check("word_hold", resp_word, last_w);
    check("chal_q_empty", exp_chal.size(), 0);
  endtask
  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; seed = 8'h00; mode = 3;
    repeat (6) begin
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_word", resp_word, 0);
      check("rst_unstable", unstable, 0);
      check("rst_chal", chal_out, 0);
      check("rst_pulse", puf_pulse, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    arm(8'h01, 0);
    wait_done(0);
    arm(8'h00, 1);
    wait_done(0);
    arm(8'h01, 0);
    wait_done(20);
    arm(8'h5A, 0);
    for (int k = 0; k < 200 && !puf_pulse; k++) @(negedge clk);
    check("pulse_seen", puf_pulse, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pulse", puf_pulse, 0);
    check("arst_busy", busy, 0);
    check("arst_chal", chal_out, 0);
    check("arst_word", resp_word, 0);
    exp_chal.delete(); exp_word.delete(); exp_unst.delete(); exp_cyc.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_rst", busy, 0);
    arm(8'hA5, 0);
    wait_done(0);
`ifdef PUF_MAJORITY_VOTE_EN
    arm(8'h01, 2);
    wait_done(0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/puf_challenge_driver.md
# puf_challenge_driver

Initiator side of the arbiter-PUF challenge/response interface. It generates a pseudo-random sequence of 8-bit challenges from a seed and applies each one to the PUF. For each challenge it launches the race pulse and captures the asynchronous response bit, then assembles RESP_BITS responses into one response word for the host. It sits between the host register interface and the arbiter-PUF macro, and is the only block that drives the PUF's pulse and challenge inputs.

## Interface
Parameters:
- RESP_BITS, 8: challenges evaluated per run and width of resp_word (1..32).
- SETTLE_CYCLES, 4: length of the pulse-low settle phase and of the pulse-high fire phase, in cycles (≥3).
- VOTES, 5: evaluations per challenge when majority voting is compiled in. Odd, 3..15.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  run request; accepted only in IDLE.
- seed  in  8  first challenge, sampled when start is accepted.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse when resp_word is valid.
- resp_word  out  RESP_BITS  collected responses; bit i is the response to challenge i.
- unstable  out  1  sticky flag: some challenge had non-unanimous votes.
- chal_out  out  8  challenge driven to the PUF.
- puf_pulse  out  1  race launch signal driven to the PUF.
- puf_resp  in  1  asynchronous PUF response.

## Operation
- Reset values: busy=0, done=0, resp_word=0, unstable=0, chal_out=0x00, puf_pulse=0, FSM=IDLE, synchronizer flops=0.
- puf_resp passes through a 2-flop synchronizer. Only the synchronized value is used.
- States:
  - IDLE: on start, load chal_out=seed (seed 0x00 is replaced by 0x01), clear resp_word and unstable, clear bit index and vote counters, then go to LOAD.
  - LOAD: 1 cycle, puf_pulse=0, chal_out stable.
  - SETTLE: SETTLE_CYCLES cycles, puf_pulse=0.
  - FIRE: SETTLE_CYCLES cycles, puf_pulse=1. On the last FIRE cycle, the synchronized response is sampled as one evaluation.
  - After each evaluation: if more evaluations remain for this challenge, go to LOAD with the same challenge. Otherwise write the bit to resp_word[index], advance the LFSR, and increment index. If index reaches RESP_BITS, go to DONE; else go to LOAD.
  - DONE: 1 cycle, done=1, busy=0, then IDLE.
- LFSR (Fibonacci): next = {c[6:0], c[7]^c[5]^c[4]^c[3]}. The challenge never becomes 0.
- busy is 1 in LOAD, SETTLE and FIRE; 0 in IDLE and DONE.
- start asserted while not in IDLE is ignored, including in DONE. A start held high over DONE is accepted in the following IDLE cycle.
- resp_word and unstable hold their values until the next accepted start.
- rst_n assertion mid-run: puf_pulse and every other output go to reset values immediately, without waiting for a clock edge. No partial result is retained.

## Timing
- Each evaluation takes E = 2·SETTLE_CYCLES+1 cycles. N = 1 without voting, or VOTES with voting.
- The start-accepting edge is cycle 0. busy rises at cycle 0+. done is high in cycle RESP_BITS·N·E+1.
- With defaults and no voting: E=9, and done is high in cycle 73.
- chal_out changes only on entry to LOAD, so it is held stable for SETTLE_CYCLES+1 cycles before puf_pulse rises.
- The sample point trails the pulse rising edge by SETTLE_CYCLES-1 cycles. This accounts for 2 cycles of synchronizer latency plus PUF resolution time.

## Configuration
- PUF_MAJORITY_VOTE_EN defined:
  - Each challenge is evaluated VOTES times.
  - A 4-bit counter counts ones. The result bit is 1 when count > VOTES/2.
  - unstable is set when 0 < count < VOTES.
- PUF_MAJORITY_VOTE_EN undefined:
  - Single evaluation per challenge (N=1).
  - Vote counter is removed.
  - unstable is tied to 0.

## Test plan
- Reset: hold rst_n low, with puf_resp toggling. All outputs are 0 and chal_out=0x00. No puf_pulse activity is allowed.
- Sequence and assembly, no voting: seed 0x01, bench drives puf_resp=chal_out[0]. Required results:
  - chal_out steps 0x01,0x02,0x04,0x08,0x11,0x23,0x47,0x8E.
  - resp_word=0x71, with done in cycle 73.
  - busy falls the same cycle done rises.
- Zero seed: seed 0x00 with puf_resp tied to 1. The first chal_out is 0x01 and resp_word=0xFF.
- Start while busy: pulse start at cycle 20 of a run. There must be no restart, the challenge sequence is unchanged, and exactly one done occurs in cycle 73.
- Asynchronous reset mid-FIRE: assert rst_n low between clock edges while puf_pulse=1. puf_pulse, busy and chal_out clear before the next clk edge. After release, the block is in IDLE and a new start runs normally.
- Voting (macro defined, VOTES=5): the bench drives 1 on 3 of 5 evaluations for challenge 0 and a constant 0 otherwise. resp_word=0x01, unstable=1, and done is in cycle 361.
